maxtrix_seq: RTL and testbench
==============================

# maxtrix_seq

Sequencer for the 4-state `maxtrix` transition-matrix datapath. It accepts a coefficient set (e12..e34) and a run request (initial vector xp/xs/xl/xti plus iteration count). It loads the coefficients into the datapath with `set`, then issues `start`/`done` cycles N times, feeding `xpn/xsn/xln/xtin` back as the next input vector. It returns the final vector through a valid/ready response port, with a per-step watchdog.

## Interface
- `W`, 32: state-vector element width.
- `EW`, 5: coefficient width.
- `NW`, 8: iteration-count width.
- `TO_CYCLES`, 64: watchdog limit, in WAIT cycles per step.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_valid`  in  1  coefficient set offered.
- `cfg_ready`  out  1  coefficient set accepted on `cfg_valid&&cfg_ready`.
- `cfg_coef`  in  9·EW  packed {e12,e13,e14,e21,e23,e24,e31,e32,e34}, e12 in the MSBs.
- `run_valid`  in  1  run request offered.
- `run_ready`  out  1  run accepted on `run_valid&&run_ready`.
- `run_iters`  in  NW  number of matrix steps.
- `run_x`  in  4·W  packed {xp,xs,xl,xti}.
- `res_valid`  out  1  result held until `res_ready`.
- `res_ready`  in  1  result consumed.
- `res_x`  out  4·W  final vector, same packing as `run_x`.
- `res_iters`  out  NW  steps completed.
- `res_err`  out  2  00 ok, 01 timeout, 10 no coefficients loaded.
- `mx_set`  out  1  to datapath `set`.
- `mx_start`  out  1  to datapath `start`.
- `mx_coef`  out  9·EW  to datapath e12_in..e34_in.
- `mx_x`  out  4·W  to datapath xp/xs/xl/xti.
- `mx_done`  in  1  datapath `done`.
- `mx_xn`  in  4·W  datapath {xpn,xsn,xln,xtin}.

## Operation
- States: IDLE, SET, START, WAIT, NEXT, RESP.
- **IDLE**
  - `cfg_ready=1`; `run_ready=!cfg_valid`, so cfg wins when both are offered in the same cycle.
  - On cfg accept: latch `cfg_coef` into the coefficient register, set `coef_ok`, go to SET.
  - On run accept: latch `run_x` into the vector register and `run_iters` into `remain`, and clear `done_cnt`.
    - If `coef_ok=0`: go to RESP with err=10.
    - Else if `run_iters=0`: go to RESP with err=00.
    - Else: go to START.
- **SET**: `mx_set=1` for exactly one cycle, then IDLE.
- **START**: `mx_start=1` for one cycle; clear the watchdog; go to WAIT.
- **WAIT**
  - `mx_done` is sampled only in this state; a `done` seen in any other state is ignored.
  - If `mx_done=1`: go to NEXT.
  - Else: increment the watchdog. When it reaches TO_CYCLES-1 without `done`, go to RESP with err=01. The vector register keeps the last good vector.
- **NEXT**: vector register ← `mx_xn`; `remain`−1; `done_cnt`+1. If the new `remain` is 0 go to RESP, else START.
- **RESP**
  - `res_valid=1`, `res_x`=vector register, `res_iters`=`done_cnt`, `res_err`=latched code.
  - All response fields are stable while `res_ready=0`.
  - Return to IDLE on the edge where `res_ready=1`.
- `mx_x` and `mx_coef` are driven continuously from their registers.
- Coefficient and vector registers are untouched outside the latch events above.
- Reset, from any state including mid-step:
  - state=IDLE, `coef_ok=0`, all registers and counters cleared.
  - All outputs 0 except `cfg_ready=1` and `run_ready=1` while `cfg_valid=0`.
  - A datapath `done` arriving after reset is ignored.
- Counter widths:
  - `remain` and `done_cnt` are NW bits, with no wrap: `done_cnt` ≤ `run_iters` ≤ 2^NW−1.
  - The watchdog is `$clog2(TO_CYCLES)` bits and saturates.

## Timing
- Outputs are registered except `cfg_ready` and `run_ready`, which are combinational from state and `cfg_valid`.
- `mx_set` is high in the cycle after the cfg-accept edge.
- `mx_start` is high in the cycle after the run-accept edge, and in the cycle after each NEXT.
- Let L = number of WAIT cycles up to and including the cycle `mx_done` is sampled high (L≥1).
  - Each step takes L+2 cycles.
  - `res_valid` rises N·(L+2) cycles after the run-accept edge.
  - For N=0 or err=10, `res_valid` rises 1 cycle after the accept edge.
- Back-to-back: with `res_ready=1` in the first RESP cycle, the next run can be accepted 1 cycle later, which is the first IDLE cycle.

## Structure
- Shared package `maxtrix_pkg` holds:
  - the state enum;
  - the `res_err` code localparams;
  - the coefficient packing order and index localparams;
  - the default widths W, EW, NW.
- One sub-module, `maxtrix_wdog`: the saturating WAIT-cycle counter with `clr`, `en`, and `expired` at TO_CYCLES-1.
- The rest (FSM and registers) stays flat in `maxtrix_seq`.

## Test plan
- **Configure and run.** Send cfg coefficients 1..9 and `run_x`={1412442,124241,436436,63464} with `run_iters`=4. Use a stub datapath with L=3 and xn=x+1 per element.
  - `mx_set` pulses 1 cycle.
  - `res_valid` rises 20 cycles after the run accept.
  - `res_x`={1412446,124245,436440,63468}, `res_iters`=4, err=00.
- **Run without configuration.** Issue a run after reset with no cfg.
  - `res_valid` rises 1 cycle after accept, err=10, `res_x`=`run_x`, `res_iters`=0.
  - `mx_start` is never asserted.
- **Watchdog.** The stub withholds `done` on step 3 of 5.
  - Timeout with err=01, `res_iters`=2, `res_x`=input+2.
  - Timeout occurs TO_CYCLES WAIT cycles after the third `mx_start`.
- **Simultaneous offers and `run_iters`=0.** Offer `cfg_valid` and `run_valid` in the same IDLE cycle.
  - cfg is accepted first; the run is accepted in the first IDLE cycle after SET.
  - With `run_iters`=0: err=00, `res_x`=`run_x`.
- **Response backpressure.** Hold `res_ready`=0 for 10 cycles.
  - `res_*` stable, no `mx_start`, `cfg_ready`=0.
  - Release `res_ready`: IDLE on the next cycle.
- **Reset mid-operation.** Assert `rst` during WAIT of step 2.
  - Next cycle: state IDLE, all outputs at reset values, `coef_ok`=0.
  - A late `mx_done` pulse produces no response.

Source files
------------

// File: rtl/maxtrix_pkg.sv
// Shared types and constants for the maxtrix sequencer: FSM states, error
// codes, coefficient packing order and default widths.
package maxtrix_pkg;

    localparam int DEF_W  = 32;
    localparam int DEF_EW = 5;
    localparam int DEF_NW = 8;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        START,
        WAIT,
        NEXT,
        RESP
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOCFG   = 2'b10;

    // Coefficients are packed MSB-first in this index order.
    localparam int NCOEF   = 9;
    localparam int IDX_E12 = 0;
    localparam int IDX_E13 = 1;
    localparam int IDX_E14 = 2;
    localparam int IDX_E21 = 3;
    localparam int IDX_E23 = 4;
    localparam int IDX_E24 = 5;
    localparam int IDX_E31 = 6;
    localparam int IDX_E32 = 7;
    localparam int IDX_E34 = 8;

    function automatic int coef_lsb(input int idx, input int ew);
        return (NCOEF - 1 - idx) * ew;
    endfunction

endpackage

// File: rtl/maxtrix_wdog.sv
// Saturating WAIT-cycle counter; expired flags the last allowed cycle of a step.
module maxtrix_wdog #(
    parameter int TO_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW    = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TO_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/maxtrix_seq.sv
// Sequencer for the maxtrix datapath: loads coefficients, iterates the
// transition matrix N times with feedback, and returns the final vector.
module maxtrix_seq
    import maxtrix_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int EW        = DEF_EW,
    parameter int NW        = DEF_NW,
    parameter int TO_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [9*EW-1:0]   cfg_coef,
    input  logic              run_valid,
    output logic              run_ready,
    input  logic [NW-1:0]     run_iters,
    input  logic [4*W-1:0]    run_x,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [4*W-1:0]    res_x,
    output logic [NW-1:0]     res_iters,
    output logic [1:0]        res_err,
    output logic              mx_set,
    output logic              mx_start,
    output logic [9*EW-1:0]   mx_coef,
    output logic [4*W-1:0]    mx_x,
    input  logic              mx_done,
    input  logic [4*W-1:0]    mx_xn
);

    state_e          state_q, state_d;
    logic [9*EW-1:0] coef_q, coef_d;
    logic            coef_ok_q, coef_ok_d;
    logic [4*W-1:0]  vec_q, vec_d;
    logic [NW-1:0]   remain_q, remain_d;
    logic [NW-1:0]   done_cnt_q, done_cnt_d;
    logic [1:0]      err_q, err_d;
    logic            mx_set_q, mx_set_d;
    logic            mx_start_q, mx_start_d;
    logic            res_valid_q, res_valid_d;
    logic            wd_clr, wd_en, wd_expired;

    maxtrix_wdog #(
        .TO_CYCLES(TO_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        coef_d     = coef_q;
        coef_ok_d  = coef_ok_q;
        vec_d      = vec_q;
        remain_d   = remain_q;
        done_cnt_d = done_cnt_q;
        err_d      = err_q;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        cfg_ready  = 1'b0;
        run_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                // A configuration offered together with a run is taken first.
                cfg_ready = 1'b1;
                run_ready = !cfg_valid;
                if (cfg_valid) begin
                    coef_d    = cfg_coef;
                    coef_ok_d = 1'b1;
                    state_d   = SET;
                end else if (run_valid) begin
                    vec_d      = run_x;
                    remain_d   = run_iters;
                    done_cnt_d = '0;
                    if (!coef_ok_q) begin
                        err_d   = ERR_NOCFG;
                        state_d = RESP;
                    end else if (run_iters == '0) begin
                        err_d   = ERR_OK;
                        state_d = RESP;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = START;
                    end
                end
            end
            SET: begin
                state_d = IDLE;
            end
            START: begin
                wd_clr  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (mx_done) begin
                    state_d = NEXT;
                end else if (wd_expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = RESP;
                end else begin
                    wd_en = 1'b1;
                end
            end
            NEXT: begin
                vec_d      = mx_xn;
                remain_d   = remain_q - NW'(1);
                done_cnt_d = done_cnt_q + NW'(1);
                state_d    = (remain_q == NW'(1)) ? RESP : START;
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mx_set_d    = (state_d == SET);
        mx_start_d  = (state_d == START);
        res_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            coef_q      <= '0;
            coef_ok_q   <= 1'b0;
            vec_q       <= '0;
            remain_q    <= '0;
            done_cnt_q  <= '0;
            err_q       <= ERR_OK;
            mx_set_q    <= 1'b0;
            mx_start_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            coef_q      <= coef_d;
            coef_ok_q   <= coef_ok_d;
            vec_q       <= vec_d;
            remain_q    <= remain_d;
            done_cnt_q  <= done_cnt_d;
            err_q       <= err_d;
            mx_set_q    <= mx_set_d;
            mx_start_q  <= mx_start_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign mx_set    = mx_set_q;
    assign mx_start  = mx_start_q;
    assign mx_coef   = coef_q;
    assign mx_x      = vec_q;
    assign res_valid = res_valid_q;
    assign res_x     = vec_q;
    assign res_iters = done_cnt_q;
    assign res_err   = err_q;

endmodule

// File: tb/tb_maxtrix_seq.sv
// Self-checking bench for maxtrix_seq with a stub datapath (xn = x + inc,
// done after a programmable number of WAIT cycles) and a spec-level model.
module tb_maxtrix_seq;
    import maxtrix_pkg::*;

    localparam int W   = 32;
    localparam int EW  = 5;
    localparam int NW  = 8;
    localparam int TO  = 64;
    localparam int CW  = 9 * EW;
    localparam int XW  = 4 * W;
    localparam int LIM = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid, cfg_ready;
    logic [CW-1:0] cfg_coef;
    logic          run_valid, run_ready;
    logic [NW-1:0] run_iters;
    logic [XW-1:0] run_x;
    logic          res_valid, res_ready;
    logic [XW-1:0] res_x;
    logic [NW-1:0] res_iters;
    logic [1:0]    res_err;
    logic          mx_set, mx_start, mx_done;
    logic [CW-1:0] mx_coef;
    logic [XW-1:0] mx_x, mx_xn;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    maxtrix_seq #(.W(W), .EW(EW), .NW(NW), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_coef(cfg_coef),
        .run_valid(run_valid), .run_ready(run_ready), .run_iters(run_iters), .run_x(run_x),
        .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x),
        .res_iters(res_iters), .res_err(res_err),
        .mx_set(mx_set), .mx_start(mx_start), .mx_coef(mx_coef), .mx_x(mx_x),
        .mx_done(mx_done), .mx_xn(mx_xn)
    );

    // Stub datapath: done on the stub_lat-th WAIT cycle, withheld on step stub_block.
    int            stub_lat, stub_block;
    int            stub_cnt = 0, stub_step = 0, start_pulses = 0, set_pulses = 0;
    logic [XW-1:0] stub_inc;
    logic          force_done, stub_done;

    always @(posedge clk) begin
        if (rst) stub_cnt <= 0;
        else if (mx_start) stub_cnt <= 1;
        else if (stub_cnt == stub_lat) stub_cnt <= 0;
        else if (stub_cnt != 0) stub_cnt <= stub_cnt + 1;
        if (mx_start) begin
            stub_step    <= stub_step + 1;
            start_pulses <= start_pulses + 1;
        end
        if (mx_set) set_pulses <= set_pulses + 1;
    end

    assign stub_done = (stub_cnt != 0) && (stub_cnt == stub_lat) && (stub_step != stub_block);
    assign mx_done   = stub_done || force_done;

    always_comb begin
        mx_xn = '0;
        for (int i = 0; i < 4; i++) mx_xn[i*W +: W] = mx_x[i*W +: W] + stub_inc[i*W +: W];
    end

    function automatic logic [XW-1:0] adv(input logic [XW-1:0] x, input logic [XW-1:0] inc, input int k);
        logic [XW-1:0] r;
        for (int i = 0; i < 4; i++) r[i*W +: W] = x[i*W +: W] + W'(k) * inc[i*W +: W];
        return r;
    endfunction

    // Expected outcome from the sequencing rules; elat counts edges after the
    // accept edge until res_valid is seen (0 = the cycle right after accept).
    task automatic model_run(input logic cok, input logic [XW-1:0] x, input logic [XW-1:0] inc,
                             input int n, input int l, input int blk,
                             output logic [XW-1:0] ex, output int eit, output logic [1:0] eerr, output int elat);
        if (!cok) begin
            ex = x; eit = 0; eerr = ERR_NOCFG; elat = 0;
        end else if (blk >= 1 && blk <= n) begin
            eit = blk - 1; ex = adv(x, inc, eit); eerr = ERR_TIMEOUT; elat = (blk - 1) * (l + 2) + TO + 1;
        end else begin
            eit = n; ex = adv(x, inc, n); eerr = ERR_OK; elat = n * (l + 2);
        end
    endtask

    function automatic logic [XW-1:0] rand_x();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [CW-1:0] rand_coef();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[CW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [CW-1:0] c);
        int n = 0;
        cfg_coef = c;
        cfg_valid = 1'b1;
        while (!cfg_ready && n < LIM) begin tick(); n++; end
        tick();
        cfg_valid = 1'b0;
        tick();
    endtask

    task automatic do_run(input logic [XW-1:0] x, input int n, output int lat);
        int w = 0;
        run_x = x;
        run_iters = NW'(n);
        run_valid = 1'b1;
        while (!run_ready && w < LIM) begin tick(); w++; end
        tick();
        run_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < LIM) begin tick(); lat++; end
        vectors++;
        if (!res_valid) begin
            miscompares++;
            $display("FAIL run_timeout res_valid=%b after %0d cycles, required 1", res_valid, lat);
        end
    endtask

    task automatic release_resp();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
        vectors++; if ({mx_set, mx_start} !== 2'b00) begin miscompares++; $display("FAIL rst_mx_ctl got %b exp 00", {mx_set, mx_start}); end
        vectors++; if ({res_x, mx_x, mx_coef} !== '0) begin miscompares++; $display("FAIL rst_data got %h/%h/%h exp 0", res_x, mx_x, mx_coef); end
        vectors++; if ({res_iters, res_err} !== '0) begin miscompares++; $display("FAIL rst_res got %h/%b exp 0", res_iters, res_err); end
        vectors++; if ({cfg_ready, run_ready} !== 2'b11) begin miscompares++; $display("FAIL rst_ready got %b exp 11", {cfg_ready, run_ready}); end
        cfg_valid = 1'b1;
        #1;
        vectors++; if (run_ready !== 1'b0) begin miscompares++; $display("FAIL rst_run_ready_cfg got %b exp 0", run_ready); end
        cfg_valid = 1'b0;
        #1;
    endtask

    task automatic test_nocfg();
        logic [XW-1:0] x, ex;
        logic [1:0]    eerr;
        int            n, eit, elat, lat, s0;
        x = rand_x();
        n = $urandom_range(1, 9);
        stub_inc = rand_x();
        s0 = start_pulses;
        model_run(1'b0, x, stub_inc, n, stub_lat, -1, ex, eit, eerr, elat);
        do_run(x, n, lat);
        vectors++; if (lat !== elat) begin miscompares++; $display("FAIL nocfg_latency got %0d exp %0d", lat, elat); end
        vectors++; if (res_err !== eerr) begin miscompares++; $display("FAIL nocfg_err got %b exp %b", res_err, eerr); end
        vectors++; if (res_x !== ex) begin miscompares++; $display("FAIL nocfg_x got %h exp %h", res_x, ex); end
        vectors++; if (res_iters !== NW'(eit)) begin miscompares++; $display("FAIL nocfg_iters got %0d exp %0d", res_iters, eit); end
        vectors++; if (start_pulses !== s0) begin miscompares++; $display("FAIL nocfg_no_start got %0d starts exp 0", start_pulses - s0); end
        release_resp();
    endtask

    task automatic test_cfg_run();
        logic [CW-1:0] c;
        logic [XW-1:0] x, ex;
        logic [1:0]    eerr;
        int            e[NCOEF];
        int            n, l, eit, elat, lat, s0;
        e[IDX_E12] = 1; e[IDX_E13] = 2; e[IDX_E14] = 3;
        e[IDX_E21] = 4; e[IDX_E23] = 5; e[IDX_E24] = 6;
        e[IDX_E31] = 7; e[IDX_E32] = 8; e[IDX_E34] = 9;
        c = '0;
        for (int k = 0; k < NCOEF; k++) c[coef_lsb(k, EW) +: EW] = EW'(e[k]);
        s0 = set_pulses;
        cfg_coef = c;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        vectors++; if (mx_set !== 1'b1) begin miscompares++; $display("FAIL cfg_set_high got %b exp 1", mx_set); end
        vectors++; if (mx_coef !== c) begin miscompares++; $display("FAIL cfg_coef got %h exp %h", mx_coef, c); end
        tick();
        vectors++; if (mx_set !== 1'b0 || set_pulses - s0 !== 1) begin miscompares++; $display("FAIL cfg_set_pulse got set=%b pulses=%0d exp 0/1", mx_set, set_pulses - s0); end

        stub_lat = 3;
        stub_inc = {4{32'd1}};
        do_run({32'd1412442, 32'd124241, 32'd436436, 32'd63464}, 4, lat);
        vectors++; if (lat !== 20) begin miscompares++; $display("FAIL run1_latency got %0d exp 20", lat); end
        vectors++; if (res_x !== {32'd1412446, 32'd124245, 32'd436440, 32'd63468}) begin miscompares++; $display("FAIL run1_x got %h", res_x); end
        vectors++; if (res_iters !== 8'd4 || res_err !== ERR_OK) begin miscompares++; $display("FAIL run1_status got %0d/%b exp 4/00", res_iters, res_err); end
        release_resp();

        for (int t = 0; t < 8; t++) begin
            x = rand_x();
            stub_inc = rand_x();
            l = $urandom_range(1, 4);
            n = $urandom_range(0, 6);
            stub_lat = l;
            model_run(1'b1, x, stub_inc, n, l, -1, ex, eit, eerr, elat);
            do_run(x, n, lat);
            vectors++; if (lat !== elat) begin miscompares++; $display("FAIL rand%0d_latency got %0d exp %0d", t, lat, elat); end
            vectors++; if (res_x !== ex) begin miscompares++; $display("FAIL rand%0d_x got %h exp %h", t, res_x, ex); end
            vectors++; if (res_iters !== NW'(eit) || res_err !== eerr) begin miscompares++; $display("FAIL rand%0d_status got %0d/%b exp %0d/%b", t, res_iters, res_err, eit, eerr); end
            release_resp();
        end
    endtask

    task automatic test_watchdog();
        logic [XW-1:0] x, ex;
        logic [1:0]    eerr;
        int            eit, elat, lat;
        x = rand_x();
        stub_inc = rand_x();
        stub_lat = $urandom_range(1, 3);
        stub_block = stub_step + 3;
        model_run(1'b1, x, stub_inc, 5, stub_lat, 3, ex, eit, eerr, elat);
        do_run(x, 5, lat);
        vectors++; if (lat !== elat) begin miscompares++; $display("FAIL wdog_latency got %0d exp %0d", lat, elat); end
        vectors++; if (res_err !== eerr) begin miscompares++; $display("FAIL wdog_err got %b exp %b", res_err, eerr); end
        vectors++; if (res_iters !== NW'(eit)) begin miscompares++; $display("FAIL wdog_iters got %0d exp %0d", res_iters, eit); end
        vectors++; if (res_x !== ex) begin miscompares++; $display("FAIL wdog_x got %h exp %h", res_x, ex); end
        release_resp();
        stub_block = -1;
    endtask

    task automatic test_simultaneous();
        logic [CW-1:0] c;
        logic [XW-1:0] x;
        c = rand_coef();
        x = rand_x();
        cfg_coef = c; cfg_valid = 1'b1;
        run_x = x; run_iters = '0; run_valid = 1'b1;
        #1;
        vectors++; if (run_ready !== 1'b0) begin miscompares++; $display("FAIL simul_run_blocked got %b exp 0", run_ready); end
        tick();
        cfg_valid = 1'b0;
        vectors++; if (mx_set !== 1'b1 || run_ready !== 1'b0) begin miscompares++; $display("FAIL simul_set got set=%b rr=%b exp 1/0", mx_set, run_ready); end
        tick();
        vectors++; if (run_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL simul_idle got rr=%b rv=%b exp 1/0", run_ready, res_valid); end
        tick();
        run_valid = 1'b0;
        vectors++; if (res_valid !== 1'b1 || res_err !== ERR_OK) begin miscompares++; $display("FAIL simul_resp got rv=%b err=%b exp 1/00", res_valid, res_err); end
        vectors++; if (res_x !== x || res_iters !== '0) begin miscompares++; $display("FAIL simul_x got %h/%0d exp %h/0", res_x, res_iters, x); end
        vectors++; if (mx_coef !== c) begin miscompares++; $display("FAIL simul_coef got %h exp %h", mx_coef, c); end
        release_resp();
    endtask

    task automatic test_backpressure();
        logic [XW-1:0] x, ex;
        logic [1:0]    eerr;
        int            eit, elat, lat, bad;
        x = rand_x();
        stub_inc = rand_x();
        stub_lat = $urandom_range(1, 4);
        model_run(1'b1, x, stub_inc, 2, stub_lat, -1, ex, eit, eerr, elat);
        do_run(x, 2, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b1 || res_x !== ex || res_iters !== NW'(eit) || res_err !== eerr ||
                mx_start !== 1'b0 || cfg_ready !== 1'b0) bad++;
            tick();
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL bp_hold got %0d unstable cycles exp 0", bad); end
        release_resp();
        vectors++; if (res_valid !== 1'b0 || cfg_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release got rv=%b cr=%b exp 0/1", res_valid, cfg_ready); end
    endtask

    task automatic test_back_to_back();
        logic [XW-1:0] x, ex;
        logic [1:0]    eerr;
        int            eit, elat, lat;
        stub_lat = 1;
        stub_inc = rand_x();
        do_run(rand_x(), 1, lat);
        x = rand_x();
        run_x = x; run_iters = 8'd1; run_valid = 1'b1; res_ready = 1'b1;
        #1;
        vectors++; if (run_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_resp_ready got %b exp 0", run_ready); end
        tick();
        res_ready = 1'b0;
        vectors++; if (run_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_idle_ready got %b exp 1", run_ready); end
        tick();
        run_valid = 1'b0;
        model_run(1'b1, x, stub_inc, 1, 1, -1, ex, eit, eerr, elat);
        lat = 0;
        while (!res_valid && lat < LIM) begin tick(); lat++; end
        vectors++; if (lat !== elat || res_x !== ex || res_err !== eerr) begin miscompares++; $display("FAIL b2b_result got lat=%0d x=%h exp lat=%0d x=%h", lat, res_x, elat, ex); end
        release_resp();
    endtask

    task automatic test_reset_mid();
        logic [XW-1:0] x;
        int            s0, w, lat, bad;
        send_cfg(rand_coef());
        stub_lat = 3;
        stub_inc = rand_x();
        x = rand_x();
        run_x = x; run_iters = 8'd4; run_valid = 1'b1;
        s0 = start_pulses;
        tick();
        run_valid = 1'b0;
        w = 0;
        while (start_pulses - s0 < 2 && w < LIM) begin tick(); w++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if ({res_valid, mx_set, mx_start} !== 3'b000) begin miscompares++; $display("FAIL rmid_ctl got %b exp 000", {res_valid, mx_set, mx_start}); end
        vectors++; if ({res_x, mx_x, mx_coef, res_iters, res_err} !== '0) begin miscompares++; $display("FAIL rmid_data got %h/%h/%h exp 0", res_x, mx_x, mx_coef); end
        vectors++; if ({cfg_ready, run_ready} !== 2'b11) begin miscompares++; $display("FAIL rmid_ready got %b exp 11", {cfg_ready, run_ready}); end
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b0 || mx_start !== 1'b0) bad++;
            tick();
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rmid_late_done got %0d active cycles exp 0", bad); end
        do_run(x, 3, lat);
        vectors++; if (lat !== 0 || res_err !== ERR_NOCFG) begin miscompares++; $display("FAIL rmid_coef_ok got lat=%0d err=%b exp 0/10", lat, res_err); end
        release_resp();
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; run_valid = 1'b0; res_ready = 1'b0; force_done = 1'b0;
        cfg_coef = '0; run_x = '0; run_iters = '0;
        stub_lat = 3; stub_block = -1; stub_inc = '0;
        test_reset();
        test_nocfg();
        test_cfg_run();
        test_watchdog();
        test_simultaneous();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
